// File: rtl/game_sequencer_if.sv
// Player/switch inputs and round-control outputs of the game sequencer.
interface game_sequencer_if;
    logic       start;
    logic [2:0] level_sw;
    logic       movement;
    logic       hit;
    logic       goal;
    logic [2:0] state;
    logic [1:0] level;
    logic [1:0] lives;
    logic       round_reset;
    logic       en_fast;
    logic       en_slow;
    logic       auto_kill;
    logic       win;
    logic       loss;

    modport master (
        output start, level_sw, movement, hit, goal,
        input  state, level, lives, round_reset,
        input  en_fast, en_slow, auto_kill, win, loss
    );

    modport slave (
        input  start, level_sw, movement, hit, goal,
        output state, level, lives, round_reset,
        output en_fast, en_slow, auto_kill, win, loss
    );
endinterface

// File: rtl/game_sequencer.sv
// Round-level controller: difficulty latch, round sequencing, shift
// enables, stand-still timeout and lives bookkeeping.
module game_sequencer #(
    parameter int TICK_BASE      = 5000000,
    parameter int IDLE_LIMIT     = 500000000,
    parameter int DISPLAY_CYCLES = 100000000,
    parameter int LIVES          = 3
) (
    input logic clk,
    input logic reset,
    game_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ARM  = 3'd1,
        PLAY = 3'd2,
        WIN  = 3'd3,
        LOSS = 3'd4,
        OVER = 3'd5
    } state_t;

    state_t      st;
    logic [1:0]  level_q;
    logic [1:0]  lives_q;
    logic        rr_q;
    logic        fast_q;
    logic        slow_q;
    logic        kill_q;
    logic        win_q;
    logic        loss_q;
    logic [31:0] fast_cnt;
    logic [31:0] slow_cnt;
    logic [31:0] idle_cnt;
    logic [31:0] disp_cnt;

    logic [31:0] fast_period;
    logic [31:0] slow_period;
    logic        fast_last;
    logic        slow_last;
    logic        kill;
    logic        disp_last;

    assign fast_period = (32'd4 - {30'd0, level_q}) * 32'(TICK_BASE);
    assign slow_period = (32'd5 - {30'd0, level_q}) * 32'(TICK_BASE);
    assign fast_last   = fast_cnt == fast_period - 32'd1;
    assign slow_last   = slow_cnt == slow_period - 32'd1;
    assign kill        = idle_cnt == 32'(IDLE_LIMIT - 1);
    assign disp_last   = disp_cnt == 32'(DISPLAY_CYCLES - 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            st       <= IDLE;
            level_q  <= 2'd0;
            lives_q  <= 2'd0;
            rr_q     <= 1'b0;
            fast_q   <= 1'b0;
            slow_q   <= 1'b0;
            kill_q   <= 1'b0;
            win_q    <= 1'b0;
            loss_q   <= 1'b0;
            fast_cnt <= 32'd0;
            slow_cnt <= 32'd0;
            idle_cnt <= 32'd0;
            disp_cnt <= 32'd0;
        end else begin
            rr_q   <= 1'b0;
            fast_q <= 1'b0;
            slow_q <= 1'b0;
            kill_q <= 1'b0;
            unique case (st)
                IDLE: begin
                    if (bus.start && bus.level_sw != 3'd0) begin
                        level_q <= bus.level_sw[0] ? 2'd0 :
                                   bus.level_sw[1] ? 2'd1 : 2'd2;
                        lives_q <= 2'(LIVES);
                        rr_q    <= 1'b1;
                        st      <= ARM;
                    end
                end
                ARM: begin
                    fast_cnt <= 32'd0;
                    slow_cnt <= 32'd0;
                    idle_cnt <= 32'd0;
                    st       <= PLAY;
                end
                PLAY: begin
                    // A timeout is handled exactly like a collision.
                    if (bus.hit || kill) begin
                        kill_q   <= kill;
                        lives_q  <= lives_q - 2'd1;
                        loss_q   <= 1'b1;
                        disp_cnt <= 32'd0;
                        st       <= (lives_q == 2'd1) ? OVER : LOSS;
                    end else if (bus.goal) begin
                        win_q    <= 1'b1;
                        disp_cnt <= 32'd0;
                        st       <= WIN;
                    end else begin
                        fast_q   <= fast_last;
                        slow_q   <= slow_last;
                        fast_cnt <= fast_last ? 32'd0 : fast_cnt + 32'd1;
                        slow_cnt <= slow_last ? 32'd0 : slow_cnt + 32'd1;
                        idle_cnt <= bus.movement ? 32'd0 : idle_cnt + 32'd1;
                    end
                end
                WIN: begin
                    if (level_q == 2'd2) begin
                        if (bus.start) begin
                            win_q <= 1'b0;
                            st    <= IDLE;
                        end
                    end else if (disp_last) begin
                        level_q <= level_q + 2'd1;
                        win_q   <= 1'b0;
                        rr_q    <= 1'b1;
                        st      <= ARM;
                    end else begin
                        disp_cnt <= disp_cnt + 32'd1;
                    end
                end
                LOSS: begin
                    if (disp_last) begin
                        loss_q <= 1'b0;
                        rr_q   <= 1'b1;
                        st     <= ARM;
                    end else begin
                        disp_cnt <= disp_cnt + 32'd1;
                    end
                end
                OVER: begin
                    if (bus.start) begin
                        loss_q <= 1'b0;
                        st     <= IDLE;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

    assign bus.state       = st;
    assign bus.level       = level_q;
    assign bus.lives       = lives_q;
    assign bus.round_reset = rr_q;
    assign bus.en_fast     = fast_q;
    assign bus.en_slow     = slow_q;
    assign bus.auto_kill   = kill_q;
    assign bus.win         = win_q;
    assign bus.loss        = loss_q;
endmodule
